// File: rtl/pcm_fifo_pkg.sv
// Shared types and constants for the PCM byte FIFO.
// A 16-bit sample leaves the FIFO as two bytes, MSB first.
package pcm_fifo_pkg;

  typedef enum logic {PHASE_MSB, PHASE_LSB} byte_phase_t;

  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned BYTES_PER_SAMPLE = 2;

endpackage

// File: rtl/pcm_byte_fifo_if.sv
// Sample-in / byte-out bus of the PCM byte FIFO.
// The master drives samples and read requests; the slave returns bytes and status.
interface pcm_byte_fifo_if
  import pcm_fifo_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned DEPTH        = 32768
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                    clear;
  logic [SAMPLE_WIDTH-1:0] pcm_in;
  logic                    pcm_valid;
  logic                    rd_en;
  logic [BYTE_W-1:0]       rd_data;
  logic                    rd_valid;
  logic                    empty;
  logic                    full;
  logic [ADDR_W:0]         level;
  logic                    overflow;

  modport master (
    output clear, pcm_in, pcm_valid, rd_en,
    input  rd_data, rd_valid, empty, full, level, overflow
  );

  modport slave (
    input  clear, pcm_in, pcm_valid, rd_en,
    output rd_data, rd_valid, empty, full, level, overflow
  );

endinterface

// File: rtl/pcm_fifo_mem.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module pcm_fifo_mem #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 32768,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pcm_byte_fifo.sv
// Circular sample buffer between the I2S capture stage and SPI readout.
// Samples go in 16 bits at a time and come out as bytes, MSB first.
module pcm_byte_fifo
  import pcm_fifo_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned DEPTH        = 32768
) (
  input  logic            clk,
  input  logic            rst_n,
  pcm_byte_fifo_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]         level_q, level_d;
  byte_phase_t             phase_q, phase_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    overflow_q, overflow_d;
  logic                    sel_lsb_q, sel_lsb_d;
  logic                    primed_q, primed_d;

  logic                    empty, full;
  logic                    push, accept, pop;
  logic                    mem_we, mem_re;
  logic [SAMPLE_WIDTH-1:0] mem_rdata;

  assign empty  = (level_q == '0);
  assign full   = (level_q == (ADDR_W + 1)'(DEPTH));
  assign push   = bus.pcm_valid && !full;
  assign accept = bus.rd_en && !empty;
  assign pop    = accept && (phase_q == PHASE_LSB);

  // The whole sample is fetched on the MSB byte; the LSB byte reuses the read register.
  assign mem_we = push && !bus.clear;
  assign mem_re = accept && (phase_q == PHASE_MSB) && !bus.clear;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    phase_d    = phase_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;
    sel_lsb_d  = sel_lsb_q;
    primed_d   = primed_q;
    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      phase_d    = PHASE_MSB;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (bus.pcm_valid && full) begin
        overflow_d = 1'b1;
      end
      if (accept) begin
        rd_valid_d = 1'b1;
        primed_d   = 1'b1;
        sel_lsb_d  = (phase_q == PHASE_LSB);
        phase_d    = (phase_q == PHASE_MSB) ? PHASE_LSB : PHASE_MSB;
        if (pop) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
      end
      level_d = level_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      phase_q    <= PHASE_MSB;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      sel_lsb_q  <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      phase_q    <= phase_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      sel_lsb_q  <= sel_lsb_d;
      primed_q   <= primed_d;
    end
  end

  pcm_fifo_mem #(
    .Width (SAMPLE_WIDTH),
    .Depth (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.pcm_in),
    .re_i    (mem_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // The RAM read register has no reset, so rd_data is forced to zero until the first read.
  assign bus.rd_data  = !primed_q ? '0 :
                        sel_lsb_q ? mem_rdata[BYTE_W-1:0] :
                                    mem_rdata[SAMPLE_WIDTH-1 -: BYTE_W];
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;

endmodule

// File: doc/pcm_byte_fifo.md
Name: pcm_byte_fifo

Overview:
- Downstream consumer of the I2S capture top level.
- Buffers 16-bit PCM samples arriving as single-cycle strobes (pcm_out/pcm_ready, about 12 kHz) in a circular RAM.
- Presents them as a byte stream, MSB byte first, to the SPI readout logic.
- Tracks fill level and flags sample loss on overflow.

Parameters:
- SAMPLE_WIDTH, 16, PCM sample width; fixed at 16 because the byte split assumes two bytes per sample.
- DEPTH, 32768, sample capacity; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), derived localparam; pointer width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- clear  in  1  synchronous flush, active-high.
- pcm_in  in  SAMPLE_WIDTH  sample from I2S stage.
- pcm_valid  in  1  one-cycle strobe qualifying pcm_in.
- rd_en  in  1  byte read request.
- rd_data  out  8  registered byte output.
- rd_valid  out  1  one-cycle strobe qualifying rd_data.
- empty  out  1  no unread sample, including a partially read one.
- full  out  1  level == DEPTH.
- level  out  ADDR_W+1  samples held, including a partially read one.
- overflow  out  1  sticky: a sample was dropped.

Behaviour:
- Reset and clock:
  - Reset rst_n, asynchronous, active-low; clock clk.
  - On reset: wr_ptr=0, rd_ptr=0, level=0, phase=PHASE_MSB, rd_data=0, rd_valid=0, overflow=0.
  - Outputs after reset: empty=1, full=0.
- Flag derivation:
  - empty = (level==0) and full = (level==DEPTH), both combinational from registered level.
  - Flags reflect pre-update state within a cycle.
- Push:
  - When pcm_valid && !full: mem[wr_ptr]<=pcm_in; wr_ptr<=wr_ptr+1, wrapping modulo DEPTH.
  - When pcm_valid && full: sample discarded, overflow<=1, pointers unchanged.
  - A pop in the same cycle does not rescue a push onto a full FIFO.
- Byte read accept:
  - rd_en is accepted only when !empty.
  - rd_en while empty is ignored: no state change, rd_valid stays 0.
- Read in PHASE_MSB:
  - rd_data<=mem[rd_ptr][15:8] and rd_valid<=1 on the next edge (latency 1).
  - phase<=PHASE_LSB; rd_ptr and level unchanged.
- Read in PHASE_LSB:
  - rd_data<=mem[rd_ptr][7:0], rd_valid<=1.
  - phase<=PHASE_MSB; rd_ptr<=rd_ptr+1 (wraps); the sample is popped here.
- Back-to-back reads:
  - rd_en may be held high for consecutive cycles; one byte per cycle.
  - rd_valid is high the cycle after each accepted rd_en and low otherwise.
  - rd_data holds its last value when rd_valid=0.
- Level update, per cycle:
  - push only: level+1.
  - LSB pop only: level-1.
  - push and LSB pop together: unchanged.
  - A write to a slot and an LSB read of a different slot in the same cycle is legal.
  - Same-slot read/write cannot occur: reading requires level>=1, writing requires level<DEPTH.
- clear:
  - Has priority over push and pop in the same cycle.
  - Next state: pointers=0, level=0, phase=PHASE_MSB, rd_valid=0, overflow=0.
  - RAM contents are not cleared.
- Reset mid-read (phase=PHASE_LSB): returns to PHASE_MSB, and the half-read sample is lost along with all contents.
- RAM: synchronous write, synchronous read, mappable to block RAM; no read-during-write hazard by construction.

Decomposition:
- Package pcm_fifo_pkg:
  - typedef enum logic {PHASE_MSB, PHASE_LSB} byte_phase_t;
  - localparam BYTE_W=8.
  - localparam BYTES_PER_SAMPLE=2.
- Sub-module pcm_fifo_mem: simple dual-port RAM, width SAMPLE_WIDTH, depth DEPTH, one write port and one registered read port.
- pcm_byte_fifo itself holds pointers, level, phase, flags and the byte mux.

Test Plan:
- Reset then push 0x1234 then push 0xABCD; rd_en high 4 cycles.
  - rd_data 0x12,0x34,0xAB,0xCD with rd_valid each cycle after rd_en.
  - level 2->1 after the 2nd byte, 0 after the 4th; empty=1 at end.
- Empty read: rd_en pulsed with level=0 -> rd_valid=0, level stays 0, phase stays PHASE_MSB.
- Overflow, DEPTH=4: push 0x0001..0x0005.
  - full=1 after the 4th push; the 5th is dropped; overflow=1.
  - Reading 8 bytes returns 00 01 00 02 00 03 00 04.
- Simultaneous push and pop, level=2, PHASE_LSB: rd_en and pcm_valid in the same cycle -> level stays 2, rd_ptr advances, new sample stored.
- Wrap-around, DEPTH=4: 10 pushes interleaved with full reads -> byte stream matches pushed values in order; pointers wrap without loss.
- Clear with overflow=1, level=3, phase=PHASE_LSB, and a concurrent pcm_valid:
  - Next cycle: level=0, empty=1, overflow=0, phase=PHASE_MSB, concurrent sample not stored.
  - Asserting rst_n mid-read gives the same state asynchronously.
